// File: rtl/xin_debounce_pulse_pkg.sv
// Shared constants for the xin input conditioner: FSM state encodings and
// the debounce counter width helper.
package xin_debounce_pulse_pkg;

    localparam logic [1:0] S_LOW  = 2'b00;
    localparam logic [1:0] S_RISE = 2'b01;
    localparam logic [1:0] S_HIGH = 2'b10;
    localparam logic [1:0] S_FALL = 2'b11;

    // A single-cycle debounce still needs a one-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/xin_debounce_pulse_bit_synchronizer.sv
// Reset-to-zero flop chain that brings an asynchronous level into the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/xin_debounce_pulse.sv
// Synchronises and debounces a raw bouncy level, then emits one-cycle pulses
// on each accepted rise (xin_pulse) and fall (fall_pulse).
module xin_debounce_pulse
    import xin_debounce_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    output logic                xin_pulse,
    output logic                level,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                w_syncQ;
    logic                w_glitchSat;
    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [GLITCH_W-1:0] r_glitchCnt;
    logic                r_xinPulse;
    logic                r_fallPulse;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (w_syncQ)
    );

    assign w_glitchSat = &r_glitchCnt;

    // Pulses default low every cycle so each can only ever last a single clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LOW;
            r_cnt       <= '0;
            r_glitchCnt <= '0;
            r_xinPulse  <= 1'b0;
            r_fallPulse <= 1'b0;
        end else begin
            r_xinPulse  <= 1'b0;
            r_fallPulse <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_syncQ) begin
                        r_state <= S_RISE;
                        r_cnt   <= '0;
                    end
                end
                S_RISE: begin
                    if (!w_syncQ) begin
                        r_state <= S_LOW;
                        if (!w_glitchSat) begin
                            r_glitchCnt <= r_glitchCnt + GLITCH_W'(1);
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= S_HIGH;
                        r_xinPulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!w_syncQ) begin
                        r_state <= S_FALL;
                        r_cnt   <= '0;
                    end
                end
                S_FALL: begin
                    if (w_syncQ) begin
                        r_state <= S_HIGH;
                        if (!w_glitchSat) begin
                            r_glitchCnt <= r_glitchCnt + GLITCH_W'(1);
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= S_LOW;
                        r_fallPulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_LOW;
            endcase
        end
    end

    // Both S_HIGH and S_FALL carry a 1 in the upper state bit.
    assign level      = r_state[1];
    assign xin_pulse  = r_xinPulse;
    assign fall_pulse = r_fallPulse;
    assign glitch_cnt = r_glitchCnt;

endmodule

// File: tb/tb_xin_debounce_pulse.sv
// Self-checking bench for xin_debounce_pulse: vector table, pulse scoreboard,
// reset, mod-4 integration and glitch-counter saturation sequences.
module tb_xin_debounce_pulse;

    localparam int LAT = 19;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       raw0 = 1'b0;
    logic       rawSat = 1'b0;
    logic       xinPulse, level0, fallPulse;
    logic [7:0] glitch0;
    logic       satXin, satLevel, satFall;
    logic [1:0] satGlitch;

    int edgeCnt = 0;
    int compared = 0;
    int errors = 0;
    int satPulses = 0;
    int riseQ[$];
    int fallQ[$];

    logic [1:0] m4;
    logic       yOut;

    typedef struct {
        logic raw;
        int   hold;
        bit   pushRise;
        bit   pushFall;
        int   expLevel;
        int   expGlitch;
    } vec_t;

    vec_t vecs[8];

    xin_debounce_pulse u_dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw0),
        .xin_pulse  (xinPulse),
        .level      (level0),
        .fall_pulse (fallPulse),
        .glitch_cnt (glitch0)
    );

    xin_debounce_pulse #(
        .GLITCH_W (2)
    ) u_sat (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (rawSat),
        .xin_pulse  (satXin),
        .level      (satLevel),
        .fall_pulse (satFall),
        .glitch_cnt (satGlitch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    // Downstream mod-4 xin counter; y_out asserts in state 11.
    always @(posedge clk or negedge reset) begin
        if (!reset) m4 <= 2'b00;
        else if (xinPulse) m4 <= m4 + 2'b01;
    end
    assign yOut = (m4 == 2'b11);

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input int hold, input bit pushRise, input bit pushFall);
        raw0 = v;
        if (pushRise) riseQ.push_back(edgeCnt + LAT);
        if (pushFall) fallQ.push_back(edgeCnt + LAT);
        repeat (hold) @(negedge clk);
    endtask

    // Pulse scoreboard: every observed pulse must match the next expected edge.
    always @(negedge clk) begin
        int expEdge;
        if (xinPulse || fallPulse) checkOutput("pulse overlap", int'(xinPulse && fallPulse), 0);
        if (xinPulse) begin
            if (riseQ.size() == 0) begin
                compared++;
                errors++;
                $display("[TB] FAIL unexpected xin_pulse: seen at edge %0d, want none", edgeCnt);
            end else begin
                expEdge = riseQ.pop_front();
                checkOutput("xin_pulse edge", edgeCnt, expEdge);
                checkOutput("level at rise", int'(level0), 1);
            end
        end
        if (fallPulse) begin
            if (fallQ.size() == 0) begin
                compared++;
                errors++;
                $display("[TB] FAIL unexpected fall_pulse: seen at edge %0d, want none", edgeCnt);
            end else begin
                expEdge = fallQ.pop_front();
                checkOutput("fall_pulse edge", edgeCnt, expEdge);
                checkOutput("level at fall", int'(level0), 0);
            end
        end
        if (satXin || satFall) satPulses++;
    end

    initial begin
        vecs[0] = '{1'b1, 16, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{1'b0,  6, 1'b0, 1'b0, 0, 1};
        vecs[2] = '{1'b1, 22, 1'b1, 1'b0, 1, 1};
        vecs[3] = '{1'b0, 16, 1'b0, 1'b0, 1, 1};
        vecs[4] = '{1'b1,  6, 1'b0, 1'b0, 1, 2};
        vecs[5] = '{1'b0, 22, 1'b0, 1'b1, 0, 2};
        vecs[6] = '{1'b1,  2, 1'b0, 1'b0, 0, 2};
        vecs[7] = '{1'b0,  6, 1'b0, 1'b0, 0, 3};

        repeat (3) @(negedge clk);
        checkOutput("reset xin_pulse", int'(xinPulse), 0);
        checkOutput("reset level", int'(level0), 0);
        checkOutput("reset fall_pulse", int'(fallPulse), 0);
        checkOutput("reset glitch_cnt", int'(glitch0), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].raw, vecs[i].hold, vecs[i].pushRise, vecs[i].pushFall);
            checkOutput($sformatf("vec%0d level", i), int'(level0), vecs[i].expLevel);
            checkOutput($sformatf("vec%0d glitch_cnt", i), int'(glitch0), vecs[i].expGlitch);
        end

        $display("[TB] clean rise and fall");
        applyStimulus(1'b1, 25, 1'b1, 1'b0);
        checkOutput("clean rise level", int'(level0), 1);
        applyStimulus(1'b0, 25, 1'b0, 1'b1);
        checkOutput("clean fall level", int'(level0), 0);
        checkOutput("clean glitch_cnt", int'(glitch0), 3);

        $display("[TB] reset mid-debounce");
        applyStimulus(1'b1, 10, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset glitch_cnt", int'(glitch0), 0);
        checkOutput("async reset level", int'(level0), 0);
        checkOutput("async reset xin_pulse", int'(xinPulse), 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 25, 1'b1, 1'b0);
        checkOutput("post-reset level", int'(level0), 1);
        checkOutput("post-reset m4", int'(m4), 1);

        $display("[TB] mod-4 integration");
        raw0 = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("m4 after reset", int'(m4), 0);
        for (int p = 1; p <= 4; p++) begin
            applyStimulus(1'b1, 22, 1'b1, 1'b0);
            checkOutput($sformatf("press%0d m4", p), int'(m4), p % 4);
            checkOutput($sformatf("press%0d y_out", p), int'(yOut), int'(p == 3));
            applyStimulus(1'b0, 22, 1'b0, 1'b1);
            checkOutput($sformatf("release%0d y_out", p), int'(yOut), int'(p == 3));
        end

        $display("[TB] bounce on rise");
        applyStimulus(1'b1, 5, 1'b0, 1'b0);
        applyStimulus(1'b0, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 4, 1'b0, 1'b0);
        applyStimulus(1'b1, 22, 1'b1, 1'b0);
        checkOutput("bounce glitch_cnt", int'(glitch0), 2);
        checkOutput("bounce level", int'(level0), 1);

        $display("[TB] glitch counter saturation");
        for (int i = 0; i < 5; i++) begin
            rawSat = 1'b1;
            repeat (5) @(negedge clk);
            rawSat = 1'b0;
            repeat (6) @(negedge clk);
            checkOutput($sformatf("sat abort%0d glitch_cnt", i), int'(satGlitch), (i + 1 > 3) ? 3 : i + 1);
        end
        checkOutput("sat pulses", satPulses, 0);
        checkOutput("sat level", int'(satLevel), 0);

        repeat (3) @(negedge clk);
        checkOutput("rise queue drained", riseQ.size(), 0);
        checkOutput("fall queue drained", fallQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
